rv32i_alu: RTL and testbench

//   RV32I integer ALU for the execute stage. Computes the arithmetic, logic, shift and compare results.

---
 rtl/rv32i_pkg.sv | 16 +
 rtl/rv32i_alu_shifter.sv | 27 ++
 rtl/rv32i_alu.sv | 99 +++++++++
 tb/tb_rv32i_alu.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I execute-stage ALU: funct3 encodings and the
// funct7 bit that selects the alternate (SUB/SRA) operation.
package rv32i_pkg;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam int F7_ALT_BIT = 5;

endpackage

// File: rtl/rv32i_alu_shifter.sv
// Barrel shifter for SLL / SRL / SRA. dir=1 shifts right; arith=1 makes a right
// shift fill with A[31].
module rv32i_alu_shifter
    import rv32i_pkg::*;
(
    input  logic [31:0] A,
    input  logic [4:0]  shamt,
    input  logic        dir,
    input  logic        arith,
    output logic [31:0] Y
);

    logic signed [32:0] extA_s;
    logic signed [32:0] shrRes_s;

    // Right shifts run on a 33-bit value whose top bit is the fill bit.
    always_comb begin
        extA_s   = {arith & A[31], A};
        shrRes_s = extA_s >>> shamt;
        if (dir) begin
            Y = shrRes_s[31:0];
        end else begin
            Y = A << shamt;
        end
    end

endmodule

// File: rtl/rv32i_alu.sv
// RV32I execute-stage ALU: combinational result Q and compare flags, plus a
// registered copy of Q for the next pipeline stage.
module rv32i_alu
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
)(
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [2:0]      func3,
    input  logic [6:0]      func7,
    input  logic [4:0]      shamt,
    input  logic            isALUreg,
    input  logic            isALUimm,
    input  logic            isBranch,
    input  logic            isJALR,
    input  logic            isJAL,
    input  logic            isAUIPC,
    input  logic            isLUI,
    input  logic            isLoad,
    input  logic            isStore,
    output logic            EQ,
    output logic            EQM,
    output logic            EQM_U,
    output logic [XLEN-1:0] Q,
    output logic [XLEN-1:0] Q_reg
);

    logic [XLEN-1:0] sum_s;
    logic [XLEN-1:0] diff_s;
    logic [XLEN-1:0] shiftRes_s;
    logic [XLEN-1:0] aluRes_s;
    logic            altOp_s;
    logic            isAddrGrp_s;
    logic            unusedFunc7_s;

    assign altOp_s       = func7[F7_ALT_BIT];
    assign unusedFunc7_s = ^{func7[6], func7[4:0]};
    assign isAddrGrp_s   = isLoad | isStore | isJALR | isJAL | isAUIPC;

    assign EQ    = (A == B);
    assign EQM   = ($signed(A) < $signed(B));
    assign EQM_U = (A < B);

    assign sum_s  = A + B;
    assign diff_s = A - B;

    rv32i_alu_shifter u_shifter (
        .A     (A),
        .shamt (shamt),
        .dir   (func3 == F3_SR),
        .arith (altOp_s),
        .Y     (shiftRes_s)
    );

    // ALU operation decode; subtract exists only for the register form.
    always_comb begin
        aluRes_s = {XLEN{1'b0}};
        case (func3)
            F3_ADD:  aluRes_s = (isALUreg && altOp_s) ? diff_s : sum_s;
            F3_SLL:  aluRes_s = shiftRes_s;
            F3_SLT:  aluRes_s = {{(XLEN-1){1'b0}}, EQM};
            F3_SLTU: aluRes_s = {{(XLEN-1){1'b0}}, EQM_U};
            F3_XOR:  aluRes_s = A ^ B;
            F3_SR:   aluRes_s = shiftRes_s;
            F3_OR:   aluRes_s = A | B;
            F3_AND:  aluRes_s = A & B;
            default: aluRes_s = {XLEN{1'b0}};
        endcase
    end

    // Result select by instruction class, highest priority first.
    always_comb begin
        Q = {XLEN{1'b0}};
        if (isALUreg || isALUimm) begin
            Q = aluRes_s;
        end else if (isLUI) begin
            Q = B;
        end else if (isAddrGrp_s) begin
            Q = sum_s;
        end else if (isBranch) begin
            Q = diff_s;
        end else begin
            Q = {XLEN{1'b0}};
        end
    end

    // Pipeline register toward the next stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Q_reg <= {XLEN{1'b0}};
        end else begin
            Q_reg <= Q;
        end
    end

endmodule

// File: tb/tb_rv32i_alu.sv
// Self-checking bench for rv32i_alu: scoreboard of expected Q / flags / Q_reg
// built from a bench-side reference model, plus directed constant checks.
module tb_rv32i_alu;

    logic        clk;
    logic        rst;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [4:0]  shamt;
    logic        isALUreg, isALUimm, isBranch, isJALR, isJAL;
    logic        isAUIPC, isLUI, isLoad, isStore;
    logic        EQ, EQM, EQM_U;
    logic [31:0] Q;
    logic [31:0] Q_reg;

    int checkCount = 0;
    int errorCount = 0;

    typedef struct {
        string       tag;
        logic [31:0] q;
        logic        eq;
        logic        eqm;
        logic        eqmu;
    } exp_t;

    exp_t sb[$];

    // class bit positions in the bench's stimulus vector
    localparam int C_REG = 0, C_IMM = 1, C_BR = 2, C_JALR = 3, C_JAL = 4;
    localparam int C_AUIPC = 5, C_LUI = 6, C_LOAD = 7, C_STORE = 8;

    rv32i_alu #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .func3(func3), .func7(func7),
        .shamt(shamt), .isALUreg(isALUreg), .isALUimm(isALUimm),
        .isBranch(isBranch), .isJALR(isJALR), .isJAL(isJAL),
        .isAUIPC(isAUIPC), .isLUI(isLUI), .isLoad(isLoad), .isStore(isStore),
        .EQ(EQ), .EQM(EQM), .EQM_U(EQM_U), .Q(Q), .Q_reg(Q_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] refSra(input logic [31:0] a, input logic [4:0] s);
        logic [31:0] r;
        r = a >> s;
        if (a[31]) r = r | ~(32'hFFFF_FFFF >> s);
        return r;
    endfunction

    function automatic logic [31:0] refQ(input logic [8:0] cls, input logic [2:0] f3,
                                         input logic [6:0] f7, input logic [4:0] s,
                                         input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        r = 32'h0;
        if (cls[C_REG] || cls[C_IMM]) begin
            case (f3)
                3'd0: r = (cls[C_REG] && f7[5]) ? a + (~b + 32'd1) : a + b;
                3'd1: r = a << s;
                3'd2: r = {31'b0, ($signed(a) < $signed(b))};
                3'd3: r = {31'b0, (a < b)};
                3'd4: r = a ^ b;
                3'd5: r = f7[5] ? refSra(a, s) : (a >> s);
                3'd6: r = a | b;
                default: r = a & b;
            endcase
        end else if (cls[C_LUI]) begin
            r = b;
        end else if (cls[C_JALR] || cls[C_JAL] || cls[C_AUIPC] || cls[C_LOAD] || cls[C_STORE]) begin
            r = a + b;
        end else if (cls[C_BR]) begin
            r = a + (~b + 32'd1);
        end
        return r;
    endfunction

    task automatic drive(input logic [8:0] cls, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] s, input logic [31:0] a, input logic [31:0] b);
        {isStore, isLoad, isLUI, isAUIPC, isJAL, isJALR, isBranch, isALUimm, isALUreg} = cls;
        func3 = f3; func7 = f7; shamt = s; A = a; B = b;
    endtask

    // Drive at negedge, push expectation, then compare after the next posedge.
    task automatic applyOp(input string tag, input logic [8:0] cls, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [4:0] s,
                           input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        @(negedge clk);
        drive(cls, f3, f7, s, a, b);
        e.tag  = tag;
        e.q    = refQ(cls, f3, f7, s, a, b);
        e.eq   = (a == b);
        e.eqm  = ($signed(a) < $signed(b));
        e.eqmu = (a < b);
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checkVal({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            checkVal({e.tag, "_Q"}, Q, e.q);
            checkVal({e.tag, "_EQ"}, {31'b0, EQ}, {31'b0, e.eq});
            checkVal({e.tag, "_EQM"}, {31'b0, EQM}, {31'b0, e.eqm});
            checkVal({e.tag, "_EQMU"}, {31'b0, EQM_U}, {31'b0, e.eqmu});
            checkVal({e.tag, "_Qreg"}, Q_reg, e.q);
        end
    endtask

    localparam logic [8:0] K_REG  = 9'b000000001;
    localparam logic [8:0] K_IMM  = 9'b000000010;
    localparam logic [8:0] K_BR   = 9'b000000100;
    localparam logic [8:0] K_LUI  = 9'b001000000;
    localparam logic [8:0] K_LOAD = 9'b010000000;
    localparam logic [8:0] K_NONE = 9'b000000000;

    initial begin
        rst = 1'b1;
        drive(K_NONE, 3'd0, 7'd0, 5'd0, 32'd0, 32'd0);
        #2;
        checkVal("reset_Qreg", Q_reg, 32'h0);
        checkVal("noflag_Q", Q, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        applyOp("add", K_REG, 3'b000, 7'b0000000, 5'd0, 32'd1, 32'd2);
        checkVal("add_const", Q, 32'h0000_0003);
        applyOp("sub", K_REG, 3'b000, 7'b0100000, 5'd0, 32'd1, 32'd2);
        checkVal("sub_const", Q, 32'hFFFF_FFFF);
        applyOp("and", K_REG, 3'b111, 7'd0, 5'd0, 32'd1, 32'd2);
        checkVal("and_const", Q, 32'h0);
        applyOp("or", K_REG, 3'b110, 7'd0, 5'd0, 32'd1, 32'd2);
        checkVal("or_const", Q, 32'h3);
        applyOp("xor", K_REG, 3'b100, 7'd0, 5'd0, 32'd1, 32'd2);
        checkVal("xor_const", Q, 32'h3);
        applyOp("sll", K_REG, 3'b001, 7'd0, 5'd1, 32'd1, 32'h0000_0700);
        checkVal("sll_const", Q, 32'h2);
        applyOp("srl", K_REG, 3'b101, 7'd0, 5'd1, 32'd1, 32'd0);
        checkVal("srl_const", Q, 32'h0);
        applyOp("sra", K_REG, 3'b101, 7'b0100000, 5'd1, 32'hFFFF_FFF0, 32'd0);
        checkVal("sra_const", Q, 32'hFFFF_FFF8);
        applyOp("srl_neg", K_REG, 3'b101, 7'd0, 5'd4, 32'h8000_0000, 32'd0);
        checkVal("srl_neg_const", Q, 32'h0800_0000);
        applyOp("slt", K_REG, 3'b010, 7'd0, 5'd0, 32'hFFFF_FFFB, 32'd3);
        checkVal("slt_const", Q, 32'h1);
        checkVal("slt_EQM", {31'b0, EQM}, 32'h1);
        checkVal("slt_EQMU", {31'b0, EQM_U}, 32'h0);
        applyOp("sltu", K_REG, 3'b011, 7'd0, 5'd0, 32'd2, 32'd3);
        checkVal("sltu_const", Q, 32'h1);
        applyOp("eq", K_BR, 3'b000, 7'd0, 5'd0, 32'd7, 32'd7);
        checkVal("eq_const", {31'b0, EQ}, 32'h1);
        applyOp("addi_nosub", K_IMM, 3'b000, 7'b0100000, 5'd0, 32'd5, 32'd3);
        checkVal("addi_const", Q, 32'h8);
        applyOp("lui", K_LUI, 3'b000, 7'd0, 5'd0, 32'hDEAD_BEEF, 32'h1234_5000);
        checkVal("lui_const", Q, 32'h1234_5000);
        applyOp("load", K_LOAD, 3'b010, 7'd0, 5'd0, 32'd100, 32'd4);
        checkVal("load_const", Q, 32'd104);
        applyOp("prio_reg_lui", K_REG | K_LUI, 3'b110, 7'd0, 5'd0, 32'h0F0F_0000, 32'h0000_00F0);
        checkVal("prio_const", Q, 32'h0F0F_00F0);
        applyOp("add_wrap", K_REG, 3'b000, 7'd0, 5'd0, 32'hFFFF_FFFF, 32'd2);
        checkVal("add_wrap_const", Q, 32'h1);

        // async reset mid-run: Q_reg clears without a clock edge, Q is unaffected
        applyOp("pre_rst", K_LUI, 3'b000, 7'd0, 5'd0, 32'd0, 32'h1234_5000);
        #1;
        rst = 1'b1;
        #1;
        checkVal("rst_async_Qreg", Q_reg, 32'h0);
        checkVal("rst_Q_comb", Q, 32'h1234_5000);
        @(negedge clk);
        rst = 1'b0;
        checkVal("rst_held_Qreg", Q_reg, 32'h0);
        @(posedge clk);
        #1;
        checkVal("rst_release_Qreg", Q_reg, 32'h1234_5000);

        for (int i = 0; i < 60; i++) begin
            logic [8:0] cls;
            cls = 9'd0;
            cls[$urandom_range(0, 8)] = 1'b1;
            if (($urandom & 32'd3) == 32'd0) cls[$urandom_range(0, 8)] = 1'b1;
            if (($urandom & 32'd15) == 32'd0) cls = 9'd0;
            applyOp("rand", cls, 3'($urandom_range(0, 7)),
                    (($urandom & 32'd1) == 32'd1) ? 7'b0100000 : 7'b0000000,
                    5'($urandom_range(0, 31)), $urandom, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
